// File: rtl/cpu_pkg.sv
// Shared definitions for the multicycle controller: opcodes, ALU operation
// codes and the controller state encoding.
package cpu_pkg;

  localparam logic [3:0] OP_ADD    = 4'h0;
  localparam logic [3:0] OP_SUB    = 4'h1;
  localparam logic [3:0] OP_XOR    = 4'h2;
  localparam logic [3:0] OP_RED    = 4'h3;
  localparam logic [3:0] OP_SLL    = 4'h4;
  localparam logic [3:0] OP_SRA    = 4'h5;
  localparam logic [3:0] OP_ROR    = 4'h6;
  localparam logic [3:0] OP_PADDSB = 4'h7;
  localparam logic [3:0] OP_LW     = 4'h8;
  localparam logic [3:0] OP_SW     = 4'h9;
  localparam logic [3:0] OP_LHB    = 4'hA;
  localparam logic [3:0] OP_LLB    = 4'hB;
  localparam logic [3:0] OP_B      = 4'hC;
  localparam logic [3:0] OP_BR     = 4'hD;
  localparam logic [3:0] OP_PCS    = 4'hE;
  localparam logic [3:0] OP_HLT    = 4'hF;

  localparam logic [2:0] ALU_ADD    = 3'd0;
  localparam logic [2:0] ALU_SUB    = 3'd1;
  localparam logic [2:0] ALU_XOR    = 3'd2;
  localparam logic [2:0] ALU_RED    = 3'd3;
  localparam logic [2:0] ALU_SLL    = 3'd4;
  localparam logic [2:0] ALU_SRA    = 3'd5;
  localparam logic [2:0] ALU_ROR    = 3'd6;
  localparam logic [2:0] ALU_PADDSB = 3'd7;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5,
    ST_ERR    = 3'd6
  } state_t;

endpackage

// File: rtl/instr_decode.sv
// Combinational opcode-to-attribute decode used by the controller FSM.
module instr_decode
  import cpu_pkg::*;
(
  input  logic [3:0] opcode_i,
  output logic [2:0] alu_op_o,
  output logic       alu_src_o,
  output logic       is_mem_o,
  output logic       is_load_o,
  output logic       is_branch_o,
  output logic       writes_reg_o
);

  always_comb begin
    alu_op_o     = ALU_ADD;
    alu_src_o    = 1'b0;
    is_mem_o     = 1'b0;
    is_load_o    = 1'b0;
    is_branch_o  = 1'b0;
    writes_reg_o = 1'b1;
    case (opcode_i)
      OP_ADD:    alu_op_o = ALU_ADD;
      OP_SUB:    alu_op_o = ALU_SUB;
      OP_XOR:    alu_op_o = ALU_XOR;
      OP_RED:    alu_op_o = ALU_RED;
      OP_SLL:    begin alu_op_o = ALU_SLL; alu_src_o = 1'b1; end
      OP_SRA:    begin alu_op_o = ALU_SRA; alu_src_o = 1'b1; end
      OP_ROR:    begin alu_op_o = ALU_ROR; alu_src_o = 1'b1; end
      OP_PADDSB: alu_op_o = ALU_PADDSB;
      OP_LW:     begin alu_src_o = 1'b1; is_mem_o = 1'b1; is_load_o = 1'b1; end
      OP_SW:     begin alu_src_o = 1'b1; is_mem_o = 1'b1; writes_reg_o = 1'b0; end
      OP_LHB,
      OP_LLB:    alu_src_o = 1'b1;
      OP_B:      begin is_branch_o = 1'b1; writes_reg_o = 1'b0; end
      OP_BR:     begin is_branch_o = 1'b1; alu_src_o = 1'b1; writes_reg_o = 1'b0; end
      OP_HLT:    writes_reg_o = 1'b0;
      default:   ;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle CPU control FSM: fetch/decode/execute/memory/writeback sequencing
// with a memory-wait watchdog and terminal HALT/ERR states.
module multicycle_ctrl
  import cpu_pkg::*;
#(
  parameter int unsigned MEM_WAIT_MAX = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] opcode,
  input  logic       cond_true,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       ir_write,
  output logic       mem_read,
  output logic       mem_write,
  output logic       mem_to_reg,
  output logic       alu_src,
  output logic       reg_write,
  output logic [2:0] alu_op,
  output logic       halted,
  output logic       mem_err
);

  localparam logic [7:0] WAIT_LAST = 8'(MEM_WAIT_MAX - 1);

  state_t     state_q;
  logic [7:0] wait_q;
  logic       active_q;
  logic       mem_err_q;

  logic [2:0] dec_alu_op;
  logic       dec_alu_src, dec_is_mem, dec_is_load, dec_is_branch, dec_writes_reg;
  state_t     mem_done_state;

  instr_decode u_dec (
    .opcode_i     (opcode),
    .alu_op_o     (dec_alu_op),
    .alu_src_o    (dec_alu_src),
    .is_mem_o     (dec_is_mem),
    .is_load_o    (dec_is_load),
    .is_branch_o  (dec_is_branch),
    .writes_reg_o (dec_writes_reg)
  );

  always_comb begin
    mem_done_state = ST_FETCH;
    if (state_q == ST_FETCH)  mem_done_state = ST_DECODE;
    else if (dec_is_load)     mem_done_state = ST_WB;
  end

  // active_q holds the FSM idle for the cycle in which reset is released,
  // so the first fetch request appears right after the first rising edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_FETCH;
      wait_q    <= '0;
      active_q  <= 1'b0;
      mem_err_q <= 1'b0;
    end else begin
      active_q <= 1'b1;
      if (active_q) begin
        case (state_q)
          ST_FETCH, ST_MEM: begin
            if (mem_ready) begin
              state_q <= mem_done_state;
              wait_q  <= '0;
            end else if (wait_q == WAIT_LAST) begin
              state_q   <= ST_ERR;
              wait_q    <= '0;
              mem_err_q <= 1'b1;
            end else begin
              wait_q <= wait_q + 8'd1;
            end
          end
          ST_DECODE: state_q <= (opcode == OP_HLT) ? ST_HALT : ST_EXEC;
          ST_EXEC: begin
            if (dec_is_branch)   state_q <= ST_FETCH;
            else if (dec_is_mem) state_q <= ST_MEM;
            else                 state_q <= ST_WB;
          end
          ST_WB:   state_q <= ST_FETCH;
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_to_reg = 1'b0;
    alu_src    = 1'b0;
    reg_write  = 1'b0;
    alu_op     = ALU_ADD;
    if (active_q) begin
      if (state_q inside {ST_EXEC, ST_MEM, ST_WB}) begin
        alu_op  = dec_alu_op;
        alu_src = dec_alu_src;
      end
      case (state_q)
        ST_FETCH: begin
          mem_read = 1'b1;
          ir_write = mem_ready;
          pc_write = mem_ready;
        end
        ST_EXEC: pc_write = dec_is_branch & cond_true;
        ST_MEM: begin
          mem_read  = dec_is_load;
          mem_write = dec_is_mem & ~dec_is_load;
        end
        ST_WB: begin
          reg_write  = dec_writes_reg;
          mem_to_reg = dec_is_load;
        end
        default: ;
      endcase
    end
    halted  = (state_q == ST_HALT);
    mem_err = mem_err_q;
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: an instruction-level model expands each
// randomized instruction into expected per-cycle outputs, a monitor compares.
module tb_multicycle_ctrl;

  localparam int WMAX = 4;
  localparam logic [3:0] T_ADD = 4'h0, T_SUB = 4'h1, T_LW = 4'h8, T_SW = 4'h9;
  localparam logic [3:0] T_B = 4'hC, T_BR = 4'hD, T_PCS = 4'hE, T_HLT = 4'hF;

  typedef struct packed {
    logic       mr, mw, irw, pcw, rw, m2r, asrc;
    logic [2:0] aop;
    logic       hlt, err;
  } outs_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] opcode = 4'h0;
  logic       cond_true = 1'b0;
  logic       mem_ready = 1'b0;
  logic       pc_write, ir_write, mem_read, mem_write, mem_to_reg, alu_src, reg_write;
  logic [2:0] alu_op;
  logic       halted, mem_err;

  outs_t expq[$];
  int    n_tests = 0;
  int    n_fail = 0;
  int    cyc_no = 0;
  logic  term_halt = 1'b0;
  logic  term_err = 1'b0;

  multicycle_ctrl #(.MEM_WAIT_MAX(WMAX)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .cond_true(cond_true),
    .mem_ready(mem_ready), .pc_write(pc_write), .ir_write(ir_write),
    .mem_read(mem_read), .mem_write(mem_write), .mem_to_reg(mem_to_reg),
    .alu_src(alu_src), .reg_write(reg_write), .alu_op(alu_op),
    .halted(halted), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] rnd4();
    return 4'($urandom);
  endfunction

  function automatic logic rbit();
    return 1'($urandom);
  endfunction

  // ALU code follows the low opcode bits for the register ALU group, ADD otherwise.
  function automatic logic [2:0] model_aop(input logic [3:0] op);
    return (op < 4'd8) ? op[2:0] : 3'd0;
  endfunction

  function automatic logic model_asrc(input logic [3:0] op);
    return op inside {4'h4, 4'h5, 4'h6, 4'h8, 4'h9, 4'hA, 4'hB, 4'hD};
  endfunction

  task automatic cyc(input logic [3:0] op, input logic c, input logic rdy, input outs_t e);
    @(posedge clk); #1;
    opcode    = op;
    cond_true = c;
    mem_ready = rdy;
    expq.push_back(e);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      rst_n     = 1'b0;
      opcode    = rnd4();
      cond_true = rbit();
      mem_ready = rbit();
      expq.push_back('0);
    end
    @(posedge clk); #1;
    rst_n     = 1'b1;
    mem_ready = 1'b1;
    expq.push_back('0);
    term_halt = 1'b0;
    term_err  = 1'b0;
  endtask

  task automatic terminal(input int n);
    outs_t e;
    e     = '0;
    e.hlt = term_halt;
    e.err = term_err;
    for (int i = 0; i < n; i++) cyc(rnd4(), rbit(), rbit(), e);
  endtask

  // Expand one instruction into its cycle sequence; wf/wm are the number of
  // cycles without mem_ready before the ready strobe in fetch and memory.
  task automatic run_instr(input logic [3:0] op, input int wf, input int wm, input logic c);
    outs_t e, base, m, w;
    e    = '0;
    e.mr = 1'b1;
    for (int i = 0; i < wf && i < WMAX; i++) cyc(rnd4(), rbit(), 1'b0, e);
    if (wf >= WMAX) begin
      term_err = 1'b1;
      return;
    end
    e.irw = 1'b1;
    e.pcw = 1'b1;
    cyc(rnd4(), rbit(), 1'b1, e);
    cyc(op, rbit(), rbit(), '0);
    if (op == T_HLT) begin
      term_halt = 1'b1;
      return;
    end
    base      = '0;
    base.aop  = model_aop(op);
    base.asrc = model_asrc(op);
    e         = base;
    if (op == T_B || op == T_BR) e.pcw = c;
    cyc(op, c, rbit(), e);
    if (op == T_B || op == T_BR) return;
    if (op == T_LW || op == T_SW) begin
      m    = base;
      m.mr = (op == T_LW);
      m.mw = (op == T_SW);
      for (int i = 0; i < wm && i < WMAX; i++) cyc(op, rbit(), 1'b0, m);
      if (wm >= WMAX) begin
        term_err = 1'b1;
        return;
      end
      cyc(op, rbit(), 1'b1, m);
      if (op == T_SW) return;
    end
    w     = base;
    w.rw  = 1'b1;
    w.m2r = (op == T_LW);
    cyc(op, rbit(), rbit(), w);
  endtask

  initial begin : monitor
    outs_t e, act;
    forever begin
      @(negedge clk);
      cyc_no++;
      if (expq.size() > 0) begin
        e   = expq.pop_front();
        act = {mem_read, mem_write, ir_write, pc_write, reg_write, mem_to_reg,
               alu_src, alu_op, halted, mem_err};
        n_tests++;
        if (act !== e) begin
          n_fail++;
          $display("FAIL outputs cycle %0d: got %b, required %b [mr mw irw pcw rw m2r asrc aop hlt err]",
                   cyc_no, act, e);
        end
      end
    end
  end

  initial begin : driver
    outs_t e;
    do_reset(3);
    run_instr(T_ADD, 0, 0, 1'b0);
    run_instr(T_LW, 0, 2, 1'b0);
    run_instr(T_B, 0, 0, 1'b0);
    run_instr(T_B, 1, 0, 1'b1);
    run_instr(T_BR, 0, 0, 1'b1);
    run_instr(T_LW, WMAX - 1, WMAX - 1, 1'b0);
    run_instr(T_SW, WMAX - 1, WMAX - 1, 1'b0);
    for (int k = 0; k < 60; k++)
      run_instr(4'($urandom_range(0, 14)), int'($urandom_range(0, WMAX - 1)),
                int'($urandom_range(0, WMAX - 1)), rbit());
    run_instr(T_HLT, 0, 0, 1'b0);
    terminal(20);
    do_reset(2);
    run_instr(T_ADD, 1, 0, 1'b0);
    // SW interrupted by reset while it waits in the memory phase
    e = '0; e.mr = 1'b1; e.irw = 1'b1; e.pcw = 1'b1;
    cyc(rnd4(), rbit(), 1'b1, e);
    cyc(T_SW, rbit(), rbit(), '0);
    e = '0; e.asrc = 1'b1;
    cyc(T_SW, rbit(), rbit(), e);
    e.mw = 1'b1;
    cyc(T_SW, rbit(), 1'b0, e);
    do_reset(1);
    run_instr(T_SUB, 0, 0, 1'b0);
    run_instr(T_ADD, WMAX, 0, 1'b0);
    terminal(6);
    do_reset(1);
    run_instr(T_SW, 0, WMAX, 1'b0);
    terminal(4);
    do_reset(1);
    run_instr(T_PCS, 0, 0, 1'b0);
    repeat (3) @(posedge clk);
    n_tests++;
    if (expq.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expected cycles unchecked, required 0", expq.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
